// File: rtl/data_receive.sv
// Receive-side BPSK packet deframer: majority-vote bit slicer, sync-word hunt,
// and serial-to-parallel payload assembly with a one-cycle valid strobe.
module data_receive #(
    parameter int                    PACKET_SIZE   = 64,
    parameter int                    WAVELENGTH    = 16,
    parameter int                    SYNC_SIZE     = 8,
    parameter logic [SYNC_SIZE-1:0]  SYNC_WORD     = 8'hA7,
    parameter int                    MAX_HUNT_BITS = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   rx_bit,
    output logic [0:PACKET_SIZE-1] packet,
    output logic                   packet_valid,
    output logic                   sync_timeout,
    output logic                   busy
);

    localparam int CNT_W  = $clog2(WAVELENGTH);
    localparam int ONES_W = $clog2(WAVELENGTH + 1);
    localparam int IDX_W  = $clog2(PACKET_SIZE + 1);
    localparam int HB_W   = $clog2(MAX_HUNT_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAVELENGTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACKET_SIZE - 1);
    localparam logic [HB_W-1:0]  HB_LIMIT = HB_W'(MAX_HUNT_BITS);

    typedef enum logic [1:0] {IDLE, HUNT, RECEIVE} state_t;

    state_t                 state_q, state_d;
    logic                   rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ONES_W-1:0]      ones_q, ones_d;
    logic [SYNC_SIZE-1:0]   sreg_q, sreg_d;
    logic [HB_W-1:0]        hunt_bits_q, hunt_bits_d;
    logic [IDX_W-1:0]       bit_index_q, bit_index_d;
    logic [0:PACKET_SIZE-1] shift_q, shift_d;
    logic [0:PACKET_SIZE-1] packet_q, packet_d;
    logic                   packet_valid_q, packet_valid_d;
    logic                   sync_timeout_q, sync_timeout_d;

    logic [31:0]            ones_sum;
    logic                   bit_done;
    logic                   bit_val;
    logic [SYNC_SIZE-1:0]   next_sreg;
    logic [HB_W-1:0]        hunt_bits_inc;

    always_comb begin
        state_d        = state_q;
        rx_prev_d      = rx_bit;
        count_d        = count_q;
        ones_d         = ones_q;
        sreg_d         = sreg_q;
        hunt_bits_d    = hunt_bits_q;
        bit_index_d    = bit_index_q;
        shift_d        = shift_q;
        packet_d       = packet_q;
        packet_valid_d = 1'b0;
        sync_timeout_d = 1'b0;

        // The current sample is folded into the vote; an exact tie decides 0.
        ones_sum      = 32'(ones_q) + 32'(rx_bit);
        bit_done      = (count_q == CNT_LAST);
        bit_val       = (ones_sum * 32'd2) > 32'(WAVELENGTH);
        next_sreg     = {sreg_q[SYNC_SIZE-2:0], bit_val};
        hunt_bits_inc = hunt_bits_q + HB_W'(1);

        if (state_q != IDLE) begin
            if (bit_done) begin
                count_d = '0;
                ones_d  = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
                ones_d  = ones_q + ONES_W'(rx_bit);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (rx_bit != rx_prev_q) begin
                    state_d     = HUNT;
                    count_d     = CNT_W'(1);
                    ones_d      = ONES_W'(rx_bit);
                    sreg_d      = '0;
                    hunt_bits_d = '0;
                end
            end
            HUNT: begin
                if (bit_done) begin
                    sreg_d      = next_sreg;
                    hunt_bits_d = hunt_bits_inc;
                    // A match on the final allowed bit wins over the timeout.
                    if (next_sreg == SYNC_WORD) begin
                        state_d     = RECEIVE;
                        bit_index_d = '0;
                    end else if (hunt_bits_inc == HB_LIMIT) begin
                        state_d        = IDLE;
                        sync_timeout_d = 1'b1;
                    end
                end
            end
            RECEIVE: begin
                if (bit_done) begin
                    for (int i = 0; i < PACKET_SIZE; i++) begin
                        if (bit_index_q == IDX_W'(i)) shift_d[i] = bit_val;
                    end
                    bit_index_d = bit_index_q + IDX_W'(1);
                    if (bit_index_q == IDX_LAST) begin
                        packet_d       = shift_d;
                        packet_valid_d = 1'b1;
                        state_d        = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            rx_prev_q      <= 1'b0;
            count_q        <= '0;
            ones_q         <= '0;
            sreg_q         <= '0;
            hunt_bits_q    <= '0;
            bit_index_q    <= '0;
            shift_q        <= '0;
            packet_q       <= '0;
            packet_valid_q <= 1'b0;
            sync_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_prev_q      <= rx_prev_d;
            count_q        <= count_d;
            ones_q         <= ones_d;
            sreg_q         <= sreg_d;
            hunt_bits_q    <= hunt_bits_d;
            bit_index_q    <= bit_index_d;
            shift_q        <= shift_d;
            packet_q       <= packet_d;
            packet_valid_q <= packet_valid_d;
            sync_timeout_q <= sync_timeout_d;
        end
    end

    assign packet       = packet_q;
    assign packet_valid = packet_valid_q;
    assign sync_timeout = sync_timeout_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_data_receive.sv
// Bench for data_receive: table of frames plus hand-built corner sequences,
// with a cycle-stamped scoreboard for packet_valid and sync_timeout pulses.
module tb_data_receive;

    localparam int         W  = 16;
    localparam int         PS = 64;
    localparam int         SS = 8;
    localparam int         MH = 32;
    localparam logic [7:0] SYNC = 8'hA7;
    localparam int         FRAME_CYC = (SS + PS) * W;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_bit = 1'b0;
    logic [0:PS-1] packet;
    logic          packet_valid;
    logic          sync_timeout;
    logic          busy;

    data_receive #(
        .PACKET_SIZE(PS), .WAVELENGTH(W), .SYNC_SIZE(SS),
        .SYNC_WORD(SYNC), .MAX_HUNT_BITS(MH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .rx_bit(rx_bit),
        .packet(packet), .packet_valid(packet_valid),
        .sync_timeout(sync_timeout), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int            cyc;
        logic [0:PS-1] data;
    } exp_t;

    typedef struct {
        string         name;
        logic [0:PS-1] pay;
        int            noise;
        int            tie_bit;
        logic [0:PS-1] exp;
    } vec_t;

    exp_t pq[$];
    int   tq[$];
    exp_t mon_e;
    int   mon_t;
    bit   chk_busy = 1'b0;
    int   busy_err = 0;
    logic line = 1'b0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endfunction

    function automatic logic [0:PS-1] pat(input int m, input int r);
        logic [0:PS-1] p;
        for (int i = 0; i < PS; i++) p[i] = ((i % m) == r);
        return p;
    endfunction

    // Scoreboard consumer: every strobe must match the head of its queue.
    always @(posedge clock) begin
        #1;
        if (packet_valid === 1'b1) begin
            if (pq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_packet_valid: got pulse at cycle %0d, required none", cyc);
            end else begin
                mon_e = pq.pop_front();
                check("pkt_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("pkt_data", packet, mon_e.data);
                check("busy_at_valid", 64'(busy), 64'd0);
            end
        end
        if (sync_timeout === 1'b1) begin
            if (tq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_sync_timeout: got pulse at cycle %0d, required none", cyc);
            end else begin
                mon_t = tq.pop_front();
                check("timeout_cycle", 64'(cyc), 64'(mon_t));
                check("busy_at_timeout", 64'(busy), 64'd0);
            end
        end
    end

    task automatic drive(input logic v);
        @(negedge clock);
        if (chk_busy && busy !== 1'b1) busy_err++;
        rx_bit = v;
        line   = v;
    endtask

    // Sends sync + payload; noise inverts the last samples of every bit,
    // tie_bit inverts exactly half the samples of one bit, abort_at pulses reset.
    task automatic send_frame(input logic [0:PS-1] pay, input int noise, input int tie_bit,
                              input bit expect_pkt, input logic [0:PS-1] exp, input int abort_at);
        logic [0:SS+PS-1] bits;
        logic             v;
        int               f0;
        bits     = {SYNC, pay};
        busy_err = 0;
        f0       = 0;
        for (int k = 0; k < SS + PS; k++) begin
            for (int s = 0; s < W; s++) begin
                if (k * W + s == abort_at) begin
                    @(negedge clock);
                    chk_busy = 1'b0;
                    rx_bit   = 1'b0;
                    line     = 1'b0;
                    #2 reset_n = 1'b0;
                    #1;
                    check("rst_mid_rx_packet", packet, 64'd0);
                    check("rst_mid_rx_busy", 64'(busy), 64'd0);
                    @(negedge clock);
                    reset_n = 1'b1;
                    return;
                end
                v = bits[k];
                if (s >= W - noise) v = ~v;
                if (k == tie_bit && s >= W / 2) v = ~v;
                drive(v);
                if (k == 0 && s == 0) begin
                    f0       = cyc;
                    chk_busy = 1'b1;
                    if (expect_pkt) pq.push_back('{f0 + FRAME_CYC, exp});
                end
            end
        end
        chk_busy = 1'b0;
        check("busy_during_frame", 64'(busy_err), 64'd0);
    endtask

    // Return the line to 0; a falling edge here legitimately starts a hunt that times out.
    task automatic gap();
        if (line) begin
            drive(1'b0);
            tq.push_back(cyc + MH * W);
            repeat (MH * W + 3) drive(1'b0);
        end else begin
            repeat (4) drive(1'b0);
        end
    endtask

    initial begin
        vec_t          vecs[5];
        logic [0:PS-1] p3, p3_tie, p1, last_pkt;
        int            f0;

        p3     = pat(3, 0);
        p1     = pat(3, 1);
        p3_tie = p3;
        p3_tie[0] = 1'b0;
        vecs[0] = '{"clean",     p3,                   0, -1,     p3};
        vecs[1] = '{"maj7",      p3,                   7, -1,     p3};
        vecs[2] = '{"tie8",      p3,                   0, SS + 0, p3_tie};
        vecs[3] = '{"all_ones",  {PS{1'b1}},           0, -1,     {PS{1'b1}}};
        vecs[4] = '{"mixed_n5",  64'hDEADBEEF01234567, 5, -1,     64'hDEADBEEF01234567};

        // Reset held with a toggling line.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            rx_bit = i[0];
        end
        #1;
        check("rst_packet", packet, 64'd0);
        check("rst_packet_valid", 64'(packet_valid), 64'd0);
        check("rst_sync_timeout", 64'(sync_timeout), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        rx_bit  = 1'b0;
        reset_n = 1'b1;
        repeat (3) drive(1'b0);

        // Asynchronous reset in the middle of a hunt.
        repeat (20) drive(1'b1);
        @(negedge clock);
        check("hunt_busy", 64'(busy), 64'd1);
        #2;
        reset_n = 1'b0;
        rx_bit  = 1'b0;
        line    = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) drive(1'b0);

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].pay, vecs[i].noise, vecs[i].tie_bit, 1'b1, vecs[i].exp, -1);
            gap();
        end
        last_pkt = vecs[4].exp;

        // Hunt timeout on alternating bits, then a good frame.
        for (int k = 0; k < MH; k++) begin
            for (int s = 0; s < W; s++) begin
                drive((k % 2) == 0);
                if (k == 0 && s == 0) begin
                    f0 = cyc;
                    tq.push_back(f0 + MH * W);
                end
            end
        end
        repeat (4) drive(1'b0);
        check("timeout_idle_busy", 64'(busy), 64'd0);
        check("packet_held", packet, last_pkt);
        send_frame(p3, 0, -1, 1'b1, p3, -1);
        gap();

        // Reset mid-RECEIVE, then a clean frame.
        send_frame(p1, 0, -1, 1'b0, p1, 600);
        repeat (3) drive(1'b0);
        send_frame(p3, 0, -1, 1'b1, p3, -1);
        gap();

        // Back-to-back: second edge lands in the first packet_valid cycle.
        send_frame(p1, 0, -1, 1'b1, p1, -1);
        send_frame(p3, 0, -1, 1'b1, p3, -1);
        gap();

        repeat (5) drive(1'b0);
        check("pending_packets", 64'(pq.size()), 64'd0);
        check("pending_timeouts", 64'(tq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
